cam_decimator: RTL and testbench

//  Parametrised camera-capture downscaler in the pclk domain. Assembles multi-byte pixels

---
 rtl/cam_decimator.sv | 251 +++++++++++++++++++++++++
 tb/tb_cam_decimator.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cam_decimator.sv
// cam_decimator
//   Camera-capture downscaler in the sensor pixel-clock domain. Sensor bytes
//   qualified by h_ref/v_sync are assembled into BYTES_PP-byte pixels, the
//   first byte received being the most significant. Every H_DIV-th pixel of
//   every V_DIV-th line is kept. Its top OUT_W bits are emitted with a linear
//   framebuffer address.
//
// Ports
//   pclk       in   sensor pixel clock (only clock)
//   reset_n    in   asynchronous active-low reset
//   enable     in   capture enable, looked at only when a frame starts
//   data_in    in   sensor byte [DATA_W]
//   h_ref      in   line-valid qualifier
//   v_sync     in   frame sync, active high
//   data_out   out  decimated pixel [OUT_W]
//   out_valid  out  one-cycle strobe qualifying data_out / wr_addr
//   wr_addr    out  out_y*(H_ACTIVE/H_DIV)+out_x [ADDR_W]
//   frame_done out  one-cycle pulse when a captured frame ends
//   line_err   out  sticky line-format error, cleared at frame start
//
// Pipeline: input register -> capture/decimate stage -> output register, so
// the last byte of a pixel sampled at edge N gives a strobe after edge N+2.
module cam_decimator #(
  parameter int DATA_W   = 8,
  parameter int BYTES_PP = 2,
  parameter int H_DIV    = 2,
  parameter int V_DIV    = 2,
  parameter int OUT_W    = 2,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 17
) (
  input  logic              pclk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] data_in,
  input  logic              h_ref,
  input  logic              v_sync,
  output logic [OUT_W-1:0]  data_out,
  output logic              out_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              frame_done,
  output logic              line_err
);

  localparam int PIX_W = DATA_W * BYTES_PP;
  localparam int H_OUT = H_ACTIVE / H_DIV;
  localparam int X_W   = $clog2(H_ACTIVE + 1);
  localparam int Y_W   = $clog2(V_ACTIVE + 1);
  localparam int PH_W  = (BYTES_PP > 1) ? $clog2(BYTES_PP) : 1;
  localparam int HD_W  = (H_DIV > 1) ? $clog2(H_DIV) : 1;
  localparam int VD_W  = (V_DIV > 1) ? $clog2(V_DIV) : 1;

  localparam logic [X_W-1:0]    X_MAX   = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0]    Y_MAX   = Y_W'(V_ACTIVE);
  localparam logic [PH_W-1:0]   PH_LAST = PH_W'(BYTES_PP - 1);
  localparam logic [HD_W-1:0]   HD_LAST = HD_W'(H_DIV - 1);
  localparam logic [VD_W-1:0]   VD_LAST = VD_W'(V_DIV - 1);
  localparam logic [ADDR_W-1:0] ROW_INC = ADDR_W'(H_OUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  // Registered sensor inputs and their one-cycle-delayed copies for edge detection.
  logic [DATA_W-1:0] data_r;
  logic              href_r, href_d_r;
  logic              vsync_r, vsync_d_r;

  state_t            state_r;
  logic [PH_W-1:0]   byte_ph_r;
  logic [X_W-1:0]    x_r;
  logic [Y_W-1:0]    y_r;
  logic [HD_W-1:0]   x_ph_r;    // x mod H_DIV
  logic [VD_W-1:0]   y_ph_r;    // y mod V_DIV
  logic [ADDR_W-1:0] col_r;     // x / H_DIV
  logic [ADDR_W-1:0] row_base_r;// (y / V_DIV) * H_OUT

  // Stage between pixel completion and the output register.
  logic              pix_valid_r;
  logic [OUT_W-1:0]  pix_data_r;
  logic [ADDR_W-1:0] pix_addr_r;

  logic              vsync_rise_s, vsync_fall_s, href_fall_s;
  logic              byte_load_s;
  logic [PIX_W-1:0]  word_next_s;
  logic              unused_word_s;

  assign vsync_rise_s = vsync_r & ~vsync_d_r;
  assign vsync_fall_s = ~vsync_r & vsync_d_r;
  assign href_fall_s  = ~href_r & href_d_r;
  // A v_sync rise pre-empts any byte arriving in the same cycle.
  assign byte_load_s  = (state_r == CAPTURE) & href_r & ~vsync_rise_s;
  // Only the MS bits reach data_out; the low bits are part of the word by definition.
  assign unused_word_s = ^word_next_s;

  // Register the sensor pins once and keep delayed copies for edge detection.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      data_r    <= '0;
      href_r    <= 1'b0;
      vsync_r   <= 1'b0;
      href_d_r  <= 1'b0;
      vsync_d_r <= 1'b0;
    end else begin
      data_r    <= data_in;
      href_r    <= h_ref;
      vsync_r   <= v_sync;
      href_d_r  <= href_r;
      vsync_d_r <= vsync_r;
    end
  end

  generate
    if (BYTES_PP > 1) begin : g_multi
      // Earlier bytes of the pixel in progress; the oldest byte sits at the top.
      logic [PIX_W-DATA_W-1:0] word_r;

      // Shift each accepted byte into the partial pixel word.
      always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
          word_r <= '0;
        end else if (byte_load_s) begin
          word_r <= word_next_s[PIX_W-DATA_W-1:0];
        end else begin
          word_r <= word_r;
        end
      end

      assign word_next_s = {word_r, data_r};
    end else begin : g_single
      assign word_next_s = data_r;
    end
  endgenerate

  // Frame FSM, position/decimation counters, incremental address and registered outputs.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      byte_ph_r   <= '0;
      x_r         <= '0;
      y_r         <= '0;
      x_ph_r      <= '0;
      y_ph_r      <= '0;
      col_r       <= '0;
      row_base_r  <= '0;
      pix_valid_r <= 1'b0;
      pix_data_r  <= '0;
      pix_addr_r  <= '0;
      data_out    <= '0;
      out_valid   <= 1'b0;
      wr_addr     <= '0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;
    end else begin
      // Output stage: a pixel already past completion still drains.
      out_valid   <= pix_valid_r;
      data_out    <= pix_data_r;
      wr_addr     <= pix_addr_r;
      pix_valid_r <= 1'b0;
      frame_done  <= 1'b0;

      if (vsync_rise_s) begin
        // Restart from any state; ending a capture reports the finished frame.
        state_r    <= SYNC;
        frame_done <= (state_r == CAPTURE);
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= IDLE;
          end
          SYNC: begin
            if (vsync_fall_s && enable) begin
              state_r    <= CAPTURE;
              byte_ph_r  <= '0;
              x_r        <= '0;
              y_r        <= '0;
              x_ph_r     <= '0;
              y_ph_r     <= '0;
              col_r      <= '0;
              row_base_r <= '0;
              line_err   <= 1'b0;
            end else if (vsync_fall_s) begin
              state_r <= IDLE;
            end else begin
              state_r <= SYNC;
            end
          end
          CAPTURE: begin
            if (href_r) begin
              if (byte_ph_r == PH_LAST) begin
                byte_ph_r <= '0;
                if (x_r < X_MAX) begin
                  x_r <= x_r + X_W'(1);
                  if (x_ph_r == HD_LAST) begin
                    x_ph_r <= '0;
                    col_r  <= col_r + ADDR_W'(1);
                  end else begin
                    x_ph_r <= x_ph_r + HD_W'(1);
                  end
                  if ((x_ph_r == '0) && (y_ph_r == '0) && (y_r < Y_MAX)) begin
                    pix_valid_r <= 1'b1;
                    pix_data_r  <= word_next_s[PIX_W-1 -: OUT_W];
                    pix_addr_r  <= row_base_r + col_r;
                  end else begin
                    pix_valid_r <= 1'b0;
                  end
                end else begin
                  // Pixel beyond the active width.
                  line_err <= 1'b1;
                end
              end else begin
                byte_ph_r <= byte_ph_r + PH_W'(1);
              end
            end else if (href_fall_s) begin
              // End of line: a non-zero byte phase means a truncated pixel.
              x_r       <= '0;
              x_ph_r    <= '0;
              col_r     <= '0;
              byte_ph_r <= '0;
              if (byte_ph_r != '0) begin
                line_err <= 1'b1;
              end else begin
                line_err <= line_err;
              end
              if (y_r < Y_MAX) begin
                y_r <= y_r + Y_W'(1);
                if (y_ph_r == VD_LAST) begin
                  y_ph_r     <= '0;
                  row_base_r <= row_base_r + ROW_INC;
                end else begin
                  y_ph_r <= y_ph_r + VD_W'(1);
                end
              end else begin
                y_r <= y_r;
              end
            end else begin
              state_r <= CAPTURE;
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cam_decimator.sv
// Directed bench for cam_decimator. Two instances share all inputs:
//   a: 2-byte pixels, 2x2 decimation, 8x4 active  -> 4x2 output (addr 0..7)
//   b: 1-byte pixels, no decimation,  4x2 active  -> 4x2 output (addr 0..7)
// Each step checks only the instance it targets.
module tb_cam_decimator;

  logic       pclk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [7:0] data_in;
  logic       h_ref;
  logic       v_sync;

  logic [1:0] a_data_out, b_data_out;
  logic       a_out_valid, b_out_valid;
  logic [3:0] a_wr_addr;
  logic [2:0] b_wr_addr;
  logic       a_frame_done, b_frame_done;
  logic       a_line_err, b_line_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fd_a     = 0;

  int qa_addr[$];
  int qa_data[$];
  int qb_addr[$];
  int qb_data[$];
  int qb_cyc[$];

  cam_decimator #(
    .DATA_W(8), .BYTES_PP(2), .H_DIV(2), .V_DIV(2), .OUT_W(2),
    .H_ACTIVE(8), .V_ACTIVE(4), .ADDR_W(4)
  ) dut_a (
    .pclk(pclk), .reset_n(reset_n), .enable(enable), .data_in(data_in),
    .h_ref(h_ref), .v_sync(v_sync), .data_out(a_data_out), .out_valid(a_out_valid),
    .wr_addr(a_wr_addr), .frame_done(a_frame_done), .line_err(a_line_err)
  );

  cam_decimator #(
    .DATA_W(8), .BYTES_PP(1), .H_DIV(1), .V_DIV(1), .OUT_W(2),
    .H_ACTIVE(4), .V_ACTIVE(2), .ADDR_W(3)
  ) dut_b (
    .pclk(pclk), .reset_n(reset_n), .enable(enable), .data_in(data_in),
    .h_ref(h_ref), .v_sync(v_sync), .data_out(b_data_out), .out_valid(b_out_valid),
    .wr_addr(b_wr_addr), .frame_done(b_frame_done), .line_err(b_line_err)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  // Log strobes away from the active edge.
  always @(negedge pclk) begin
    if (a_out_valid) begin
      qa_addr.push_back(32'(a_wr_addr));
      qa_data.push_back(32'(a_data_out));
    end
    if (b_out_valid) begin
      qb_addr.push_back(32'(b_wr_addr));
      qb_data.push_back(32'(b_data_out));
      qb_cyc.push_back(cyc);
    end
    if (a_frame_done) fd_a <= fd_a + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [7:0] d, input logic h, input logic v);
    data_in = d;
    h_ref   = h;
    v_sync  = v;
    @(posedge pclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(8'h00, 1'b0, 1'b0);
  endtask

  task automatic vsync_pulse();
    for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b1);
    idle(3);
  endtask

  task automatic send_line(input int nbytes, input logic [7:0] b_even, input logic [7:0] b_odd);
    for (int i = 0; i < nbytes; i++) step((i % 2 == 0) ? b_even : b_odd, 1'b1, 1'b0);
    idle(4);
  endtask

  initial begin
    int ma, mb, fa;
    int edge_cyc[8];
    logic [7:0] pat[4];
    pat[0] = 8'h00; pat[1] = 8'h40; pat[2] = 8'h80; pat[3] = 8'hC0;

    reset_n = 1'b0;
    enable  = 1'b0;
    data_in = 8'h00;
    h_ref   = 1'b0;
    v_sync  = 1'b0;
    idle(3);
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_wr_addr", 32'(a_wr_addr), 32'd0);
    check("rst_data_out", 32'(a_data_out), 32'd0);
    check("rst_frame_done", 32'(a_frame_done), 32'd0);
    check("rst_line_err", 32'(a_line_err), 32'd0);
    reset_n = 1'b1;
    idle(2);

    // 1: full frame of {C0,00}; fifth line lies beyond V_ACTIVE.
    enable = 1'b1;
    vsync_pulse();
    ma = qa_addr.size();
    fa = fd_a;
    for (int l = 0; l < 5; l++) send_line(16, 8'hC0, 8'h00);
    check("t1_line_err", 32'(a_line_err), 32'd0);
    vsync_pulse();
    check("t1_frame_done_cnt", 32'(fd_a - fa), 32'd1);
    check("t1_strobes", 32'(qa_addr.size() - ma), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check("t1_addr", 32'(qa_addr[ma + i]), 32'(i));
      check("t1_data", 32'(qa_data[ma + i]), 32'd3);
    end

    // 2: undecimated single-byte pixels with latency check.
    mb = qb_addr.size();
    for (int l = 0; l < 2; l++) begin
      for (int j = 0; j < 4; j++) begin
        step(pat[j], 1'b1, 1'b0);
        edge_cyc[l * 4 + j] = cyc;
      end
      idle(4);
    end
    idle(2);
    check("t2_strobes", 32'(qb_addr.size() - mb), 32'd8);
    for (int k = 0; k < 8; k++) begin
      check("t2_addr", 32'(qb_addr[mb + k]), 32'(k));
      check("t2_data", 32'(qb_data[mb + k]), 32'(k % 4));
      check("t2_latency", 32'(qb_cyc[mb + k]), 32'(edge_cyc[k] + 2));
    end

    // 3: truncated line, realignment, sticky error, overflowing line.
    vsync_pulse();
    ma = qa_addr.size();
    send_line(5, 8'hC0, 8'h00);
    check("t3_err_short", 32'(a_line_err), 32'd1);
    check("t3_strobes_short", 32'(qa_addr.size() - ma), 32'd1);
    check("t3_addr_short", 32'(qa_addr[ma]), 32'd0);
    send_line(4, 8'hC0, 8'h00);
    send_line(4, 8'h40, 8'h00);
    check("t3_strobes_realign", 32'(qa_addr.size() - ma), 32'd2);
    check("t3_addr_realign", 32'(qa_addr[ma + 1]), 32'd4);
    check("t3_data_realign", 32'(qa_data[ma + 1]), 32'd1);
    check("t3_err_sticky", 32'(a_line_err), 32'd1);
    vsync_pulse();
    check("t3_err_cleared", 32'(a_line_err), 32'd0);
    ma = qa_addr.size();
    send_line(18, 8'hC0, 8'h00);
    check("t3_strobes_long", 32'(qa_addr.size() - ma), 32'd4);
    check("t3_addr_long_last", 32'(qa_addr[ma + 3]), 32'd3);
    check("t3_err_long", 32'(a_line_err), 32'd1);

    // 4: frame started with enable low is skipped entirely.
    enable = 1'b0;
    vsync_pulse();
    ma = qa_addr.size();
    fa = fd_a;
    for (int l = 0; l < 4; l++) send_line(16, 8'hC0, 8'h00);
    check("t4_no_strobes", 32'(qa_addr.size() - ma), 32'd0);
    enable = 1'b1;
    vsync_pulse();
    check("t4_no_frame_done", 32'(fd_a - fa), 32'd0);
    ma = qa_addr.size();
    send_line(16, 8'hC0, 8'h00);
    check("t4_strobes", 32'(qa_addr.size() - ma), 32'd4);
    check("t4_first_addr", 32'(qa_addr[ma]), 32'd0);

    // 5: asynchronous reset mid-frame.
    send_line(16, 8'hC0, 8'h00);
    send_line(5, 8'hC0, 8'h00);
    check("t5_pre_addr", 32'(a_wr_addr), 32'd4);
    check("t5_pre_err", 32'(a_line_err), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_rst_addr", 32'(a_wr_addr), 32'd0);
    check("t5_rst_err", 32'(a_line_err), 32'd0);
    check("t5_rst_data", 32'(a_data_out), 32'd0);
    @(posedge pclk);
    #1;
    reset_n = 1'b1;
    ma = qa_addr.size();
    send_line(16, 8'hC0, 8'h00);
    check("t5_no_strobes", 32'(qa_addr.size() - ma), 32'd0);
    vsync_pulse();
    ma = qa_addr.size();
    send_line(16, 8'hC0, 8'h00);
    check("t5_strobes", 32'(qa_addr.size() - ma), 32'd4);
    check("t5_first_addr", 32'(qa_addr[ma]), 32'd0);

    // 6: v_sync rise on the pixel-completing byte.
    vsync_pulse();
    ma = qa_addr.size();
    fa = fd_a;
    step(8'hC0, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    idle(4);
    check("t6_no_strobe", 32'(qa_addr.size() - ma), 32'd0);
    check("t6_frame_done", 32'(fd_a - fa), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
